// File: rtl/rf_wb_if.sv
// Writeback arbiter bus: two requester channels, hold control, and the
// register-file write port with its write counter.
interface rf_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              HOLD;
    logic              A_valid;
    logic [ADDR_W-1:0] A_wa;
    logic [DATA_W-1:0] A_wd;
    logic              A_ready;
    logic              B_valid;
    logic [ADDR_W-1:0] B_wa;
    logic [DATA_W-1:0] B_wd;
    logic              B_ready;
    logic              RF_en;
    logic [ADDR_W-1:0] RF_wa;
    logic [DATA_W-1:0] RF_wd;
    logic [15:0]       WB_cnt;

    modport slave (
        input  HOLD, A_valid, A_wa, A_wd, B_valid, B_wa, B_wd,
        output A_ready, B_ready, RF_en, RF_wa, RF_wd, WB_cnt
    );

    modport master (
        output HOLD, A_valid, A_wa, A_wd, B_valid, B_wa, B_wd,
        input  A_ready, B_ready, RF_en, RF_wa, RF_wd, WB_cnt
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter with alternating priority,
// one-cycle registered write port and a saturating write counter.
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic   CLK,
    input  logic   RST,
    rf_wb_if.slave bus
);
    typedef enum logic {PRI_A, PRI_B} pri_t;

    pri_t              pri_q, pri_d;
    logic              en_q, en_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              a_ready, b_ready;
    logic              xfer_a, xfer_b;

    // Grant is purely combinational; reset masks it so nothing is accepted
    // while the write port is being cleared.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!RST && !bus.HOLD) begin
            if (bus.A_valid && (!bus.B_valid || pri_q == PRI_A))
                a_ready = 1'b1;
            else if (bus.B_valid)
                b_ready = 1'b1;
        end
    end

    assign xfer_a = bus.A_valid && a_ready;
    assign xfer_b = bus.B_valid && b_ready;

    always_comb begin
        pri_d = pri_q;
        en_d  = 1'b0;
        wa_d  = wa_q;
        wd_d  = wd_q;
        if (xfer_a) begin
            pri_d = PRI_B;
            wa_d  = bus.A_wa;
            wd_d  = bus.A_wd;
            en_d  = (bus.A_wa != '0);
        end else if (xfer_b) begin
            pri_d = PRI_A;
            wa_d  = bus.B_wa;
            wd_d  = bus.B_wd;
            en_d  = (bus.B_wa != '0);
        end
        cnt_d = cnt_q;
        if (en_d && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pri_q <= PRI_A;
            en_q  <= 1'b0;
            wa_q  <= '0;
            wd_q  <= '0;
            cnt_q <= '0;
        end else begin
            pri_q <= pri_d;
            en_q  <= en_d;
            wa_q  <= wa_d;
            wd_q  <= wd_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.A_ready = a_ready;
    assign bus.B_ready = b_ready;
    assign bus.RF_en   = en_q;
    assign bus.RF_wa   = wa_q;
    assign bus.RF_wd   = wd_q;
    assign bus.WB_cnt  = cnt_q;
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of the write-data path.
REQ-002 Parameter ADDR_W, default 5, width of the register address.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 HOLD  input  1  when 1, no new request is granted.
REQ-006 A_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-007 A_wa  input  ADDR_W  requester A destination register.
REQ-008 A_wd  input  DATA_W  requester A write data.
REQ-009 A_ready  output  1  requester A accepted this cycle.
REQ-010 B_valid, B_wa, B_wd, B_ready  same widths and meaning as REQ-006..009, for requester B (load writeback).
REQ-011 RF_en  output  1  register-file write enable.
REQ-012 RF_wa  output  ADDR_W  register-file write address.
REQ-013 RF_wd  output  DATA_W  register-file write data.
REQ-014 WB_cnt  output  16  count of writes issued with RF_en=1, saturating.

Function
REQ-015 Handshake: a transfer occurs on a rising edge where X_valid=1 and X_ready=1; X_ready is combinational from valid, HOLD and priority state.
REQ-016 At most one of A_ready, B_ready is 1 in any cycle; both are 0 when HOLD=1.
REQ-017 Only one requester valid and HOLD=0: that requester gets ready=1.
REQ-018 Both valid and HOLD=0: the requester holding priority gets ready=1; the other gets ready=0.
REQ-019 Priority state has two states, PRI_A and PRI_B; after a transfer from A it becomes PRI_B, after a transfer from B it becomes PRI_A; unchanged in cycles with no transfer.
REQ-020 Requester rule (checked by verification, not enforced): once valid=1, valid, wa and wd stay stable until the transfer.
REQ-021 Output latency is exactly one cycle: on the edge of a transfer, RF_wa/RF_wd register the granted wa/wd and RF_en registers 1 if wa != 0, else 0.
REQ-022 In a cycle with no transfer, RF_en registers 0; RF_wa/RF_wd retain their previous values.
REQ-023 A write to address 0 is accepted (ready=1, priority toggles) but produces RF_en=0 and does not increment WB_cnt.
REQ-024 WB_cnt increments by 1 on every edge where RF_en registers 1, and holds at 16'hFFFF without wrapping.
REQ-025 Same-address requests from A and B in one cycle are written in grant order on consecutive cycles; the later write wins in the register file.
REQ-026 HOLD asserted with valid requests pending: no transfer occurs, priority state is unchanged, and RF_en=0 on the next edge.
REQ-027 Back-to-back: with both valid continuously and HOLD=0, grants alternate every cycle and RF_en stays 1 while addresses are non-zero.

Reset
REQ-028 RST=1 immediately forces RF_en=0, RF_wa=0, RF_wd=0, WB_cnt=0 and priority=PRI_A, independent of CLK.
REQ-029 While RST=1, A_ready=0 and B_ready=0.
REQ-030 A write registered in the edge before RST rises is lost if RST rises before the next edge; no partial write is issued after reset.
REQ-031 After RST falls, the first rising edge behaves as a normal cycle with priority PRI_A.

Verification
REQ-032 Reset, then A_valid=1, A_wa=5, A_wd=32'h1234 for one cycle -> A_ready=1; next cycle RF_en=1, RF_wa=5, RF_wd=32'h1234, WB_cnt=1.
REQ-033 Both valid continuously (A_wa=3, A_wd=32'hA, B_wa=3, B_wd=32'hB) for 4 cycles from reset -> grants A,B,A,B; RF_wd sequence A,B,A,B; WB_cnt=4.
REQ-034 B_valid=1, B_wa=0, B_wd=32'hFFFF -> B_ready=1; next cycle RF_en=0; WB_cnt unchanged; priority becomes PRI_A.
REQ-035 HOLD=1 for 3 cycles with both valid -> both ready=0 and RF_en=0 throughout; on HOLD=0 the requester that held priority before HOLD is granted first.
REQ-036 Preload WB_cnt to 16'hFFFE through repeated writes, then issue 3 more non-zero writes -> WB_cnt reads 16'hFFFF and stays there.
REQ-037 Assert RST mid-cycle between a grant and its output edge -> RF_en=0 immediately; after release, RF_en stays 0 until a new transfer.
